des_key_schedule: RTL
=====================

// Module: des_key_schedule
// PURPOSE
//  Generates the 16 DES 48-bit round subkeys (PC-1, per-round C/D rotation, PC-2) from a 64-bit key.
//  Emits one subkey per round, in order K1..K16 for encrypt or K16..K1 for decrypt.
//  Sits upstream of the round engine and drives the 48-bit key input of the f-function.
//  Delivery uses a valid/ready handshake so the round engine may stall.
// PARAMETERS
//  none (all tables are fixed by the DES standard)
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  key_valid      in   1   key/decrypt valid
//  key_ready      out  1   block idle, can accept key
//  key            in   64  DES key, [1:64], bit 1 = MSB, bits 8,16..64 = parity
//  decrypt        in   1   1 = emit K16..K1, 0 = emit K1..K16; sampled with key
//  subkey_valid   out  1   subkey valid
//  subkey_ready   in   1   round engine consumes subkey
//  subkey         out  48  round subkey, [1:48], bit 1 = MSB
//  round_idx      out  4   emitted position 0..15 (0 = first emitted)
//  subkey_last    out  1   high with the 16th subkey
//  key_parity_err out  1   present only with DES_KS_PARITY_CHK_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: FSM=IDLE, C=D=0, counter=0; key_ready=1, subkey_valid=0, subkey=0, round_idx=0, subkey_last=0, key_parity_err=0.
//  FSM states:
//   IDLE: key_ready=1.
//    key_valid&key_ready -> RUN.
//    C,D <= PC1(key) halves, pre-rotated for the first round: encrypt ROL 1; decrypt no rotation.
//    Latch dir <= decrypt; cnt <= 0.
//   RUN: key_ready=0, subkey_valid=1.
//    subkey = PC2(C,D), driven from registers, with no combinational path from inputs.
//    round_idx=cnt; subkey_last=(cnt==15).
//    subkey_valid&subkey_ready & cnt<15: cnt++; C,D rotate by the next shift.
//     Encrypt: ROL by SHIFT[cnt+1]. Decrypt: ROR by DSHIFT[cnt+1].
//    subkey_valid&subkey_ready & cnt==15 -> IDLE; key_ready=1 the next cycle.
//  SHIFT  = {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}; DSHIFT = {0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}.
//  Rotations are 28-bit circular, applied to C and D independently.
//  Latency: first subkey valid 1 cycle after key accept; 1 subkey/cycle while subkey_ready=1.
//  Minimum 17 cycles from accept until key_ready rises.
//  Stall: subkey_ready=0 holds subkey, round_idx, C, D and cnt unchanged, for any duration.
//  key_valid while key_ready=0 is ignored; no queuing. key and decrypt may change freely after accept.
//  subkey_valid never drops before its handshake.
//  Reset mid-RUN: immediate return to the reset state; any partial sequence is discarded.
// CONFIGURATION
//  DES_KS_PARITY_CHK_EN defined:
//   On accept, check odd parity of each of the 8 key bytes.
//   key_parity_err <= 1 if any byte has even parity, else 0; it holds until the next accept.
//   Subkey generation proceeds regardless of the result.
//  DES_KS_PARITY_CHK_EN undefined:
//   No checker logic; key_parity_err is driven constant 0 and the port is retained.
// STRUCTURE
//  Package des_pkg holds:
//   - PC1 table (56 x 6-bit);
//   - PC2 table (48 x 6-bit);
//   - SHIFT/DSHIFT (16 x 2-bit);
//   - subkey_t [1:48] and half_t [1:28] typedefs;
//   - the state enum {IDLE, RUN}.
//  One combinational sub-module, des_ks_pc2: 56-bit {C,D} in -> 48-bit subkey out, pure permutation.
// TESTING
//  1. key=133457799BBCDFF1, decrypt=0, subkey_ready=1:
//     cycle 1 subkey=1B02EFFC7072, next subkey=79AED9DBC9E5.
//     16th subkey=CB3D8B0E17F5 with subkey_last=1; key_ready=1 the next cycle.
//  2. Same key, decrypt=1: first subkey=CB3D8B0E17F5, second=(enc K15), 16th=1B02EFFC7072.
//  3. Case 1 with subkey_ready=0 for 5 cycles at round_idx=7:
//     subkey and round_idx are stable throughout, and the full sequence matches case 1.
//  4. key_valid pulsed while in RUN with key=0: ignored, and the sequence continues unaltered.
//  5. rst_n asserted at round_idx=9: all outputs at reset values asynchronously.
//     After release, a new key is accepted and its sequence restarts at round_idx=0.
//  6. DES_KS_PARITY_CHK_EN: key 133457799BBCDFF1 -> key_parity_err=0; key 0000000000000000 -> key_parity_err=1.
//     In both cases the subkeys are still emitted.

Source files
------------

// File: rtl/des_key_schedule_pkg.sv
// DES key-schedule tables, bit-ordered types and helpers shared by the key schedule files.
package des_pkg;

  typedef logic [1:64] key_t;
  typedef logic [1:56] cd_t;
  typedef logic [1:48] subkey_t;
  typedef logic [1:28] half_t;

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [5:0] PC1 [56] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [5:0] PC2 [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // DSHIFT[i] is SHIFT[16-i]: walking the rotations backwards from K16.
  localparam logic [1:0] SHIFT  [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                         2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  localparam logic [1:0] DSHIFT [16] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                         2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  function automatic cd_t pc1(input key_t k);
    cd_t r;
    for (int i = 0; i < 56; i++) r[i+1] = k[{1'b0, PC1[i]}];
    return r;
  endfunction

  function automatic half_t rol(input half_t h, input logic [1:0] n);
    case (n)
      2'd1:    return {h[2:28], h[1]};
      2'd2:    return {h[3:28], h[1:2]};
      default: return h;
    endcase
  endfunction

  function automatic half_t ror(input half_t h, input logic [1:0] n);
    case (n)
      2'd1:    return {h[28], h[1:27]};
      2'd2:    return {h[27:28], h[1:26]};
      default: return h;
    endcase
  endfunction

  function automatic logic key_parity_ok(input key_t k);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) ok &= ^k[8*b+1 +: 8];
    return ok;
  endfunction

endpackage

// File: rtl/des_key_schedule_if.sv
// Key-in / subkey-out handshake bundle; master is the key schedule, slave the key source and round engine.
interface des_key_schedule_if
  import des_pkg::*;
;
  logic       key_valid;
  logic       key_ready;
  key_t       key;
  logic       decrypt;
  logic       subkey_valid;
  logic       subkey_ready;
  subkey_t    subkey;
  logic [3:0] round_idx;
  logic       subkey_last;
  logic       key_parity_err;

  modport master (
    input  key_valid, key, decrypt, subkey_ready,
    output key_ready, subkey_valid, subkey, round_idx, subkey_last, key_parity_err
  );

  modport slave (
    output key_valid, key, decrypt, subkey_ready,
    input  key_ready, subkey_valid, subkey, round_idx, subkey_last, key_parity_err
  );
endinterface

// File: rtl/des_ks_pc2.sv
// PC-2 compression: 56-bit {C,D} to a 48-bit round subkey, pure wiring.
module des_ks_pc2
  import des_pkg::*;
(
  input  cd_t     cd,
  output subkey_t subkey
);
  always_comb begin
    subkey = '0;
    for (int i = 0; i < 48; i++) subkey[i+1] = cd[PC2[i]];
  end
endmodule

// File: rtl/des_key_schedule.sv
// DES round-subkey generator with valid/ready delivery, K1..K16 or K16..K1.
// Optional odd-parity key check enabled by defining DES_KS_PARITY_CHK_EN.
//   state | meaning
//   IDLE  | key_ready high, waiting for a key
//   RUN   | presenting subkey PC2(C,D) for position cnt
module des_key_schedule
  import des_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  des_key_schedule_if.master bus
);
  state_t     state, state_nxt;
  half_t      c, d, c_nxt, d_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       dir, dir_nxt;
  cd_t        pc1_key;
  subkey_t    sk;

  assign pc1_key = pc1(bus.key);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      c     <= '0;
      d     <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_nxt;
      c     <= c_nxt;
      d     <= d_nxt;
      cnt   <= cnt_nxt;
      dir   <= dir_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    c_nxt            = c;
    d_nxt            = d;
    cnt_nxt          = cnt;
    dir_nxt          = dir;
    bus.key_ready    = 1'b0;
    bus.subkey_valid = 1'b0;
    bus.subkey_last  = 1'b0;
    unique case (state)
      IDLE: begin
        bus.key_ready = 1'b1;
        if (bus.key_valid) begin
          state_nxt = RUN;
          dir_nxt   = bus.decrypt;
          cnt_nxt   = '0;
          // Decrypt starts at K16, whose total rotation of 28 leaves C0/D0 unchanged.
          c_nxt     = bus.decrypt ? pc1_key[1:28]  : rol(pc1_key[1:28], SHIFT[0]);
          d_nxt     = bus.decrypt ? pc1_key[29:56] : rol(pc1_key[29:56], SHIFT[0]);
        end
      end
      RUN: begin
        bus.subkey_valid = 1'b1;
        bus.subkey_last  = (cnt == 4'd15);
        if (bus.subkey_ready) begin
          if (cnt == 4'd15) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 4'd1;
            c_nxt   = dir ? ror(c, DSHIFT[cnt_nxt]) : rol(c, SHIFT[cnt_nxt]);
            d_nxt   = dir ? ror(d, DSHIFT[cnt_nxt]) : rol(d, SHIFT[cnt_nxt]);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  des_ks_pc2 u_pc2 (
    .cd     ({c, d}),
    .subkey (sk)
  );

  assign bus.subkey    = sk;
  assign bus.round_idx = cnt;

`ifdef DES_KS_PARITY_CHK_EN
  logic parity_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              parity_err <= 1'b0;
    else if (bus.key_valid && bus.key_ready) parity_err <= ~key_parity_ok(bus.key);
  end

  assign bus.key_parity_err = parity_err;
`else
  assign bus.key_parity_err = 1'b0;
`endif

endmodule
